// File: rtl/trap_commit_ctrl_pkg.sv
// Shared types for the commit-stage trap sequencer: exception pack, FSM states,
// CSR addresses, mstatus bit positions and the status-update helpers.
package ExceptStruct;

    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } ExceptPack;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_EPC    = 3'd1,
        WR_CAUSE  = 3'd2,
        WR_TVAL   = 3'd3,
        WR_STATUS = 3'd4,
        REDIRECT  = 3'd5
    } TrapState;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Interrupt-enable stacking performed on trap entry.
    function automatic logic [63:0] trap_status(input logic [63:0] st,
                                                input logic [1:0]  old_priv,
                                                input logic        to_s);
        logic [63:0] r;
        r = st;
        if (to_s) begin
            r[MSTATUS_SPIE] = st[MSTATUS_SIE];
            r[MSTATUS_SIE]  = 1'b0;
            r[MSTATUS_SPP]  = old_priv[0];
        end else begin
            r[MSTATUS_MPIE] = st[MSTATUS_MIE];
            r[MSTATUS_MIE]  = 1'b0;
            r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = old_priv;
        end
        return r;
    endfunction

    function automatic logic [63:0] xret_status(input logic [63:0] st,
                                                input logic        is_mret);
        logic [63:0] r;
        r = st;
        if (is_mret) begin
            r[MSTATUS_MIE]  = st[MSTATUS_MPIE];
            r[MSTATUS_MPIE] = 1'b1;
            r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        end else begin
            r[MSTATUS_SIE]  = st[MSTATUS_SPIE];
            r[MSTATUS_SPIE] = 1'b1;
            r[MSTATUS_SPP]  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/trap_target_sel.sv
// Trap target selection: delegation decision, CSR address triple and
// direct-mode vector base for the latched target.
module trap_target_sel
    import ExceptStruct::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_smode_en,
    input  logic [1:0]      i_priv,
    input  logic [5:0]      i_cause_idx,
    input  logic [XLEN-1:0] i_medeleg,
    input  logic            i_to_s,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_stvec,
    output logic            o_deleg,
    output logic [11:0]     o_addr_epc,
    output logic [11:0]     o_addr_cause,
    output logic [11:0]     o_addr_tval,
    output logic [XLEN-1:0] o_tvec_base
);
    localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    assign o_deleg      = i_smode_en && (i_priv != PRIV_M) && i_medeleg[i_cause_idx];
    assign o_addr_epc   = i_to_s ? CSR_SEPC   : CSR_MEPC;
    assign o_addr_cause = i_to_s ? CSR_SCAUSE : CSR_MCAUSE;
    assign o_addr_tval  = i_to_s ? CSR_STVAL  : CSR_MTVAL;
    // Vectored mode is not supported; the low mode bits are simply dropped.
    assign o_tvec_base  = (i_to_s ? i_stvec : i_mtvec) & PC_MASK;

endmodule

// File: rtl/trap_commit_ctrl.sv
// Commit-stage trap/xRET sequencer driving the CSR write port, flush and fetch redirect.
// Optional S-mode delegation and sret support: define TRAP_SMODE_DELEG_EN.
module trap_commit_ctrl
    import ExceptStruct::*;
#(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rstn,
    input  ExceptPack       except_commit,
    input  logic            mret_commit,
    input  logic            sret_commit,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] sepc_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] stvec_i,
    input  logic [XLEN-1:0] medeleg_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            flush_o,
    output logic            busy_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic [1:0]      priv_o
);
`ifdef TRAP_SMODE_DELEG_EN
    localparam logic SMODE_EN = 1'b1;
    logic w_sret;
    assign w_sret = sret_commit;
`else
    localparam logic SMODE_EN = 1'b0;
    logic w_sret;
    logic w_unused_sret;
    assign w_sret        = 1'b0;
    assign w_unused_sret = sret_commit;
`endif

    TrapState        r_state, w_state_next;
    logic [1:0]      r_priv;
    logic            r_to_s, r_is_trap, r_is_mret;
    logic [XLEN-1:0] r_epc, r_cause, r_tval, r_redirect_pc;

    logic            w_deleg;
    logic [11:0]     w_addr_epc, w_addr_cause, w_addr_tval;
    logic [XLEN-1:0] w_tvec_base, w_status;
    logic [1:0]      w_new_priv;

    trap_target_sel #(.XLEN(XLEN)) u_sel (
        .i_smode_en  (SMODE_EN),
        .i_priv      (r_priv),
        .i_cause_idx (except_commit.ecause[5:0]),
        .i_medeleg   (medeleg_i),
        .i_to_s      (r_to_s),
        .i_mtvec     (mtvec_i),
        .i_stvec     (stvec_i),
        .o_deleg     (w_deleg),
        .o_addr_epc  (w_addr_epc),
        .o_addr_cause(w_addr_cause),
        .o_addr_tval (w_addr_tval),
        .o_tvec_base (w_tvec_base)
    );

    assign w_status = r_is_trap ? trap_status(mstatus_i, r_priv, r_to_s)
                                : xret_status(mstatus_i, r_is_mret);

    always_comb begin
        w_new_priv = r_to_s ? PRIV_S : PRIV_M;
        if (!r_is_trap)
            w_new_priv = r_is_mret ? mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]
                                   : {1'b0, mstatus_i[MSTATUS_SPP]};
    end

    // Priority in IDLE: exception, then mret, then sret.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (except_commit.except)       w_state_next = WR_EPC;
                else if (mret_commit || w_sret) w_state_next = WR_STATUS;
            end
            WR_EPC:    w_state_next = WR_CAUSE;
            WR_CAUSE:  w_state_next = WR_TVAL;
            WR_TVAL:   w_state_next = WR_STATUS;
            WR_STATUS: w_state_next = REDIRECT;
            REDIRECT:  if (redirect_ready_i) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_priv        <= RESET_PRIV;
            r_to_s        <= 1'b0;
            r_is_trap     <= 1'b0;
            r_is_mret     <= 1'b0;
            r_epc         <= '0;
            r_cause       <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE) begin
                if (except_commit.except) begin
                    r_is_trap <= 1'b1;
                    r_is_mret <= 1'b0;
                    r_to_s    <= w_deleg;
                    r_epc     <= except_commit.epc;
                    r_cause   <= except_commit.ecause;
                    r_tval    <= except_commit.etval;
                end else if (mret_commit) begin
                    r_is_trap     <= 1'b0;
                    r_is_mret     <= 1'b1;
                    r_to_s        <= 1'b0;
                    r_redirect_pc <= mepc_i;
                end else if (w_sret) begin
                    r_is_trap     <= 1'b0;
                    r_is_mret     <= 1'b0;
                    r_to_s        <= 1'b0;
                    r_redirect_pc <= sepc_i;
                end
            end
            if (r_state == WR_TVAL)
                r_redirect_pc <= w_tvec_base;
            if (r_state == WR_STATUS)
                r_priv <= w_new_priv;
        end
    end

    always_comb begin
        csr_we_o    = 1'b0;
        csr_addr_o  = 12'h000;
        csr_wdata_o = '0;
        case (r_state)
            WR_EPC:    begin csr_we_o = 1'b1; csr_addr_o = w_addr_epc;   csr_wdata_o = r_epc;   end
            WR_CAUSE:  begin csr_we_o = 1'b1; csr_addr_o = w_addr_cause; csr_wdata_o = r_cause; end
            WR_TVAL:   begin csr_we_o = 1'b1; csr_addr_o = w_addr_tval;  csr_wdata_o = r_tval;  end
            WR_STATUS: begin csr_we_o = 1'b1; csr_addr_o = CSR_MSTATUS;  csr_wdata_o = w_status; end
            default:   ;
        endcase
    end

    assign busy_o           = (r_state != IDLE);
    assign flush_o          = (r_state != IDLE);
    assign redirect_valid_o = (r_state == REDIRECT);
    assign redirect_pc_o    = r_redirect_pc;
    assign priv_o           = r_priv;

endmodule

// File: tb/tb_trap_commit_ctrl.sv
// Bench for trap_commit_ctrl: transaction-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_trap_commit_ctrl;
    import ExceptStruct::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    ExceptPack   pack;
    logic        mret_commit = 1'b0, sret_commit = 1'b0;
    logic [63:0] mstatus_i = '0, mepc_i = '0, sepc_i = '0, mtvec_i = '0, stvec_i = '0, medeleg_i = '0;
    logic        redirect_ready_i = 1'b1;
    logic        csr_we_o, flush_o, busy_o, redirect_valid_o;
    logic [11:0] csr_addr_o;
    logic [63:0] csr_wdata_o, redirect_pc_o;
    logic [1:0]  priv_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
`ifdef TRAP_SMODE_DELEG_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    trap_commit_ctrl dut (
        .clk(clk), .rstn(rstn), .except_commit(pack),
        .mret_commit(mret_commit), .sret_commit(sret_commit),
        .mstatus_i(mstatus_i), .mepc_i(mepc_i), .sepc_i(sepc_i),
        .mtvec_i(mtvec_i), .stvec_i(stvec_i), .medeleg_i(medeleg_i),
        .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .flush_o(flush_o), .busy_o(busy_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i), .priv_o(priv_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Model: pending CSR writes in order, then a pending redirect.
    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
        logic        set_priv;
        logic [1:0]  priv;
    } wr_t;
    wr_t         m_wq[$];
    logic        m_redir = 1'b0;
    logic [63:0] m_pc = '0;
    logic [1:0]  m_priv = 2'b11;
    logic [63:0] a_st;
    logic [1:0]  a_np;
    logic [11:0] a_base;
    wr_t         a_w;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_wq.delete();
            m_redir = 1'b0;
            m_priv  = 2'b11;
        end else if (m_wq.size() != 0) begin
            if (m_wq[0].set_priv) m_priv = m_wq[0].priv;
            void'(m_wq.pop_front());
        end else if (m_redir) begin
            if (redirect_ready_i) m_redir = 1'b0;
        end else if (pack.except) begin
            a_st = mstatus_i;
            if (SMODE && m_priv != 2'b11 && medeleg_i[pack.ecause[5:0]]) begin
                a_base = 12'h100;
                a_st[5] = mstatus_i[1];
                a_st[1] = 1'b0;
                a_st[8] = m_priv[0];
                a_np = 2'b01;
                m_pc = {stvec_i[63:2], 2'b00};
            end else begin
                a_base = 12'h300;
                a_st[7] = mstatus_i[3];
                a_st[3] = 1'b0;
                a_st[12:11] = m_priv;
                a_np = 2'b11;
                m_pc = {mtvec_i[63:2], 2'b00};
            end
            a_w = '{a_base + 12'h41, pack.epc,    1'b0, 2'b00}; m_wq.push_back(a_w);
            a_w = '{a_base + 12'h42, pack.ecause, 1'b0, 2'b00}; m_wq.push_back(a_w);
            a_w = '{a_base + 12'h43, pack.etval,  1'b0, 2'b00}; m_wq.push_back(a_w);
            a_w = '{12'h300, a_st, 1'b1, a_np};                 m_wq.push_back(a_w);
            m_redir = 1'b1;
        end else if (mret_commit) begin
            a_st = mstatus_i;
            a_np = mstatus_i[12:11];
            a_st[3] = mstatus_i[7];
            a_st[7] = 1'b1;
            a_st[12:11] = 2'b00;
            a_w = '{12'h300, a_st, 1'b1, a_np}; m_wq.push_back(a_w);
            m_pc = mepc_i;
            m_redir = 1'b1;
        end else if (sret_commit && SMODE) begin
            a_st = mstatus_i;
            a_np = {1'b0, mstatus_i[8]};
            a_st[1] = mstatus_i[5];
            a_st[5] = 1'b1;
            a_st[8] = 1'b0;
            a_w = '{12'h300, a_st, 1'b1, a_np}; m_wq.push_back(a_w);
            m_pc = sepc_i;
            m_redir = 1'b1;
        end
    end

    logic e_we, e_valid, e_busy;
    always @(negedge clk) begin
        if (cmp_en) begin
            e_we    = (m_wq.size() != 0);
            e_busy  = e_we || m_redir;
            e_valid = m_redir && !e_we;
            chk("cmp_busy",  64'(busy_o),           64'(e_busy));
            chk("cmp_flush", 64'(flush_o),          64'(e_busy));
            chk("cmp_we",    64'(csr_we_o),         64'(e_we));
            chk("cmp_valid", 64'(redirect_valid_o), 64'(e_valid));
            chk("cmp_priv",  64'(priv_o),           64'(m_priv));
            if (e_we) begin
                chk("cmp_addr",  64'(csr_addr_o), 64'(m_wq[0].addr));
                chk("cmp_wdata", csr_wdata_o,     m_wq[0].data);
            end
            if (e_valid) chk("cmp_pc", redirect_pc_o, m_pc);
            if (!rstn) begin
                chk("cmp_rst_pc",   redirect_pc_o,     64'h0);
                chk("cmp_rst_addr", 64'(csr_addr_o),  64'h0);
                chk("cmp_rst_data", csr_wdata_o,       64'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ex, input logic mr, input logic sr);
        pack.except = ex; mret_commit = mr; sret_commit = sr;
        step();
        pack.except = 1'b0; mret_commit = 1'b0; sret_commit = 1'b0;
        $display("TXN ex=%0b mret=%0b sret=%0b cause=%0d epc=%h", ex, mr, sr, pack.ecause, pack.epc);
    endtask

    task automatic exp_w(input string nm, input logic [11:0] addr, input logic [63:0] data);
        @(negedge clk);
        chk({nm, "_we"},   64'(csr_we_o),   64'h1);
        chk({nm, "_addr"}, 64'(csr_addr_o), 64'(addr));
        chk({nm, "_data"}, csr_wdata_o,     data);
    endtask

    task automatic exp_r(input string nm, input logic [63:0] pc);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(redirect_valid_o), 64'h1);
        chk({nm, "_pc"},    redirect_pc_o,         pc);
        chk({nm, "_we"},    64'(csr_we_o),         64'h0);
    endtask

    task automatic exp_idle(input string nm, input logic [1:0] pr);
        @(negedge clk);
        chk({nm, "_busy"}, 64'(busy_o), 64'h0);
        chk({nm, "_priv"}, 64'(priv_o), 64'(pr));
    endtask

    initial begin
        pack = '0;
        #2 rstn = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_we",    64'(csr_we_o),         64'h0);
        chk("rst_busy",  64'(busy_o),           64'h0);
        chk("rst_flush", 64'(flush_o),          64'h0);
        chk("rst_valid", 64'(redirect_valid_o), 64'h0);
        chk("rst_pc",    redirect_pc_o,         64'h0);
        chk("rst_priv",  64'(priv_o),           64'h3);
        step(); rstn = 1'b1;

        // Trap from M, ecause 2
        step();
        pack.epc = 64'h8000_0010; pack.ecause = 64'd2; pack.etval = 64'hdead_beef;
        mtvec_i = 64'h8000_0101; mstatus_i = 64'h8;
        pulse(1'b1, 1'b0, 1'b0);
        exp_w("t1_epc",    12'h341, 64'h8000_0010);
        exp_w("t1_cause",  12'h342, 64'h2);
        exp_w("t1_tval",   12'h343, 64'hdead_beef);
        exp_w("t1_status", 12'h300, 64'h1880);
        exp_r("t1_redir",  64'h8000_0100);
        exp_idle("t1_done", 2'b11);

        // mret to U
        step();
        mstatus_i = 64'h80; mepc_i = 64'h8000_0400;
        pulse(1'b0, 1'b1, 1'b0);
        exp_w("mret_status", 12'h300, 64'h88);
        exp_r("mret_redir",  64'h8000_0400);
        exp_idle("mret_done", 2'b00);

        // Trap from U with medeleg[8] set
        step();
        pack.epc = 64'h8000_0020; pack.ecause = 64'd8; pack.etval = 64'h0;
        medeleg_i = 64'h100; stvec_i = 64'h8000_2000; mstatus_i = 64'h2;
        pulse(1'b1, 1'b0, 1'b0);
        if (SMODE) begin
            exp_w("deleg_epc",    12'h141, 64'h8000_0020);
            exp_w("deleg_cause",  12'h142, 64'h8);
            exp_w("deleg_tval",   12'h143, 64'h0);
            exp_w("deleg_status", 12'h300, 64'h20);
            exp_r("deleg_redir",  64'h8000_2000);
            exp_idle("deleg_done", 2'b01);
        end else begin
            exp_w("nodeleg_epc",    12'h341, 64'h8000_0020);
            exp_w("nodeleg_cause",  12'h342, 64'h8);
            exp_w("nodeleg_tval",   12'h343, 64'h0);
            exp_w("nodeleg_status", 12'h300, 64'h2);
            exp_r("nodeleg_redir",  64'h8000_0100);
            exp_idle("nodeleg_done", 2'b11);
        end

        // sret
        step();
        mstatus_i = 64'h20; sepc_i = 64'h8000_0300;
        pulse(1'b0, 1'b0, 1'b1);
        if (SMODE) begin
            exp_w("sret_status", 12'h300, 64'h22);
            exp_r("sret_redir",  64'h8000_0300);
            exp_idle("sret_done", 2'b00);
        end else begin
            exp_idle("sret_ignored", 2'b11);
        end

        // except and mret together: trap wins, mepc unused
        step();
        medeleg_i = 64'h0; mstatus_i = 64'h8; mepc_i = 64'h1234_5678; mtvec_i = 64'h8000_0004;
        pack.epc = 64'h8000_0040; pack.ecause = 64'd5; pack.etval = 64'h55;
        pulse(1'b1, 1'b1, 1'b0);
        exp_w("both_epc", 12'h341, 64'h8000_0040);
        repeat (3) @(negedge clk);
        exp_r("both_redir", 64'h8000_0004);

        // Redirect back-pressure for 3 cycles, second except ignored
        step();
        redirect_ready_i = 1'b0; mtvec_i = 64'h8000_0800;
        pack.epc = 64'h8000_0060; pack.ecause = 64'd3; pack.etval = 64'h66;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (4) step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(redirect_valid_o), 64'h1);
            chk("hold_pc",    redirect_pc_o,         64'h8000_0800);
            chk("hold_flush", 64'(flush_o),          64'h1);
            step();
            pack.except = (k == 0);
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        chk("hold_last_valid", 64'(redirect_valid_o), 64'h1);
        step();
        @(negedge clk);
        chk("hold_release_busy", 64'(busy_o),   64'h0);
        chk("hold_release_we",   64'(csr_we_o), 64'h0);

        // Reset during WR_CAUSE, then a fresh trap
        step();
        mtvec_i = 64'h8000_0101; mstatus_i = 64'h8;
        pack.epc = 64'h8000_0050; pack.ecause = 64'd1; pack.etval = 64'h11;
        pulse(1'b1, 1'b0, 1'b0);
        exp_w("rst2_epc", 12'h341, 64'h8000_0050);
        step();
        rstn = 1'b0;
        #1;
        chk("rst2_we",    64'(csr_we_o),         64'h0);
        chk("rst2_busy",  64'(busy_o),           64'h0);
        chk("rst2_valid", 64'(redirect_valid_o), 64'h0);
        chk("rst2_pc",    redirect_pc_o,         64'h0);
        chk("rst2_priv",  64'(priv_o),           64'h3);
        step(); rstn = 1'b1;
        step();
        pulse(1'b1, 1'b0, 1'b0);
        exp_w("after_epc",    12'h341, 64'h8000_0050);
        exp_w("after_cause",  12'h342, 64'h1);
        exp_w("after_tval",   12'h343, 64'h11);
        exp_w("after_status", 12'h300, 64'h1880);
        exp_r("after_redir",  64'h8000_0100);
        exp_idle("after_done", 2'b11);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
